// File: rtl/ram2e_pkg.sv
// Shared definitions for the RAM2E SDRAM sequencer: SDRAM command
// encodings as {nCS,nRAS,nCAS,nRWE}, the mode-register builder, the
// slot numbers used by the PHI-cycle sequencer and the init state type.
package ram2e_pkg;

  localparam logic [3:0] CMD_DESL = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  // Mode word: single-location writes (A9), CAS latency in A6:4,
  // sequential bursts of length 1, everything else zero.
  function automatic logic [12:0] mode_word(input int cl);
    logic [12:0] m;
    m      = '0;
    m[9]   = 1'b1;
    m[6:4] = 3'(cl);
    return m;
  endfunction

  localparam logic [3:0] SLOT_VACT = 4'd2;
  localparam logic [3:0] SLOT_VRD  = 4'd3;
  localparam logic [3:0] SLOT_CROW = 4'd7;
  localparam logic [3:0] SLOT_CACT = 4'd8;
  localparam logic [3:0] SLOT_CRW  = 4'd9;
  localparam logic [3:0] SLOT_BANK = 4'd11;
  localparam logic [3:0] SLOT_REF  = 4'd13;
  localparam logic [3:0] SLOT_VROW = 4'd15;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PALL,
    ST_MRS,
    ST_IREF,
    ST_RUN
  } init_state_t;

endpackage

// File: rtl/ram2e_init_seq.sv
// SDRAM power-up sequence: NOP wait, PRECHARGE ALL, mode register write,
// a burst of auto-refreshes, then Ready. Command and address are registered.
module ram2e_init_seq
  import ram2e_pkg::*;
#(
  parameter int CL       = 2,
  parameter int ROW_W    = 12,
  parameter int INIT_CYC = 4000,
  parameter int INIT_REF = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [3:0]       cmd,
  output logic [ROW_W-1:0] addr,
  output logic             ready
);

  localparam logic [12:0] MODE      = mode_word(CL);
  localparam logic [15:0] WAIT_LAST = 16'(INIT_CYC - 1);

  init_state_t state;
  logic [15:0] cnt;
  logic [7:0]  ref_cnt;

  // Init FSM; cnt counts wait cycles, then the NOP gap after each command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_WAIT;
      cnt     <= '0;
      ref_cnt <= '0;
      cmd     <= CMD_DESL;
      addr    <= '0;
      ready   <= 1'b0;
    end else begin
      cmd  <= CMD_NOP;
      addr <= '0;
      case (state)
        ST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt      <= '0;
            state    <= ST_PALL;
            cmd      <= CMD_PALL;
            addr[10] <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_PALL: begin
          if (cnt == 16'd2) begin
            cnt   <= '0;
            state <= ST_MRS;
            cmd   <= CMD_MRS;
            addr  <= MODE[ROW_W-1:0];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_MRS: begin
          if (cnt == 16'd2) begin
            cnt     <= '0;
            state   <= ST_IREF;
            cmd     <= CMD_REF;
            ref_cnt <= 8'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_IREF: begin
          // Refreshes are 8 cycles apart; the last one also gets its 8 cycles
          if (cnt == 16'd7) begin
            cnt <= '0;
            if (ref_cnt == 8'(INIT_REF)) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              cmd     <= CMD_REF;
              ref_cnt <= ref_cnt + 8'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_RUN: ;
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: rtl/ram2e_sdram_ctl.sv
// RAM2E SDRAM sequencer top. One video read and one CPU access per PHI
// cycle, refresh every REF_PHI cycles, optional RAMWorks bank register
// enabled by defining RWBANK_EN.
module ram2e_sdram_ctl
  import ram2e_pkg::*;
#(
  parameter int CL       = 2,
  parameter int ROW_W    = 12,
  parameter int INIT_CYC = 4000,
  parameter int INIT_REF = 8,
  parameter int REF_PHI  = 8
) (
  input  logic             C14M,
  input  logic             nRST,
  input  logic             PHI1,
  input  logic             nWE,
  input  logic             nWE80,
  input  logic             nC07X,
  input  logic             EN80,
  input  logic             n8MEGEN,
  input  logic             nRWKSEN,
  input  logic [7:0]       Ain,
  input  logic [7:0]       Din,
  output logic [7:0]       Dout,
  output logic [7:0]       Vout,
  output logic             nDOE,
  output logic             nVOE,
  output logic             Ready,
  output logic             CKE,
  output logic             nCS,
  output logic             nRAS,
  output logic             nCAS,
  output logic             nRWE,
  output logic [1:0]       BA,
  output logic [ROW_W-1:0] RA,
  output logic             DQML,
  output logic             DQMH,
  input  logic [7:0]       RDin,
  output logic [7:0]       RDout,
  output logic             RDOE
);

  localparam int         REF_W    = (REF_PHI > 2) ? $clog2(REF_PHI) : 1;
  localparam logic [3:0] VCAP     = 4'(SLOT_VRD + CL + 1);
  localparam logic [3:0] CCAP     = 4'(SLOT_CRW + CL + 1);
  localparam logic [3:0] VRD_LAST = 4'(SLOT_VRD + CL - 1);
  localparam logic [3:0] CRW_LAST = 4'(SLOT_CRW + CL - 1);

  logic [3:0]       init_cmd;
  logic [ROW_W-1:0] init_addr;
  logic             ready;
  logic [3:0]       s;
  logic             phi1_q;
  logic [REF_W-1:0] phi_cnt;
  logic [7:0]       vrow;
  logic [7:0]       crow;
  logic [7:0]       bank;
  logic [3:0]       cmd_run;
  logic [1:0]       ba_run;
  logic [ROW_W-1:0] ra_run;
  logic             dqml_run;
  logic             dqmh_run;

  ram2e_init_seq #(
    .CL       (CL),
    .ROW_W    (ROW_W),
    .INIT_CYC (INIT_CYC),
    .INIT_REF (INIT_REF)
  ) u_init (
    .clk   (C14M),
    .rst_n (nRST),
    .cmd   (init_cmd),
    .addr  (init_addr),
    .ready (ready)
  );

  // Slot counter restarts on every PHI1 rise once ready, parks at 0 or 15
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      s       <= 4'd0;
      phi1_q  <= 1'b0;
      phi_cnt <= '0;
    end else begin
      phi1_q <= PHI1;
      if (PHI1 && !phi1_q && ready) begin
        s       <= 4'd1;
        phi_cnt <= phi_cnt + REF_W'(1);
      end else if (s != 4'd0 && s != 4'd15) begin
        s <= s + 4'd1;
      end
    end
  end

  // Row latches: video row during S15, CPU row during S7
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      vrow <= '0;
      crow <= '0;
    end else begin
      if (s == SLOT_VROW) vrow <= Ain;
      if (s == SLOT_CROW) crow <= Ain;
    end
  end

`ifdef RWBANK_EN
  logic q;

  // RAMWorks bank register: qualifier at S7, write at S11; nRWKSEN high
  // (jumper off) forces bank 0, n8MEGEN high limits the bank to 6 bits
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      q    <= 1'b0;
      bank <= '0;
    end else begin
      if (s == SLOT_CROW) q <= Ain[0] & ~Ain[3] & ~nWE;
      if (s == SLOT_BANK && !nC07X && q) begin
        if (nRWKSEN)      bank <= 8'h00;
        else if (n8MEGEN) bank <= {2'b00, Din[5:0]};
        else              bank <= Din;
      end
    end
  end
`else
  logic unused_bank_inputs;
  assign bank               = 8'h00;
  assign unused_bank_inputs = ^{nC07X, n8MEGEN, nRWKSEN};
`endif

  // Slot decode for normal operation; DQM windows cover the CAS latency
  always_comb begin
    cmd_run  = CMD_NOP;
    ba_run   = 2'b00;
    ra_run   = '0;
    dqml_run = 1'b1;
    dqmh_run = 1'b1;
    case (s)
      SLOT_VACT: begin
        cmd_run     = CMD_ACT;
        ra_run[7:0] = vrow;
      end
      SLOT_VRD: begin
        cmd_run     = CMD_RD;
        ra_run[10]  = 1'b1;
        ra_run[7:0] = Ain;
      end
      SLOT_CACT: begin
        cmd_run      = CMD_ACT;
        ba_run       = bank[5:4];
        ra_run[11:8] = bank[3:0];
        ra_run[7:0]  = crow;
        if (ROW_W > 12) ra_run[ROW_W-1] = bank[7];
      end
      SLOT_CRW: begin
        cmd_run     = nWE80 ? CMD_RD : CMD_WR;
        ba_run      = bank[5:4];
        ra_run[10]  = 1'b1;
        ra_run[7:0] = Ain;
      end
      SLOT_REF: begin
        if (phi_cnt == '0) cmd_run = CMD_REF;
      end
      default: ;
    endcase
    if (s >= SLOT_VRD && s <= VRD_LAST) begin
      dqml_run = 1'b0;
      dqmh_run = 1'b1;
    end
    if (s >= SLOT_CRW && s <= CRW_LAST) begin
      dqml_run = bank[6];
      dqmh_run = ~bank[6];
    end
  end

  // Read data capture mid-cycle, CL+1 slots after each READ
  always_ff @(negedge C14M or negedge nRST) begin
    if (!nRST) begin
      Vout <= '0;
      Dout <= '0;
    end else begin
      if (ready && s == VCAP) Vout <= RDin;
      if (ready && s == CCAP) Dout <= RDin;
    end
  end

  assign {nCS, nRAS, nCAS, nRWE} = ready ? cmd_run : init_cmd;
  assign RA    = ready ? ra_run : init_addr;
  assign BA    = ready ? ba_run : 2'b00;
  assign DQML  = ready ? dqml_run : 1'b1;
  assign DQMH  = ready ? dqmh_run : 1'b1;
  assign Ready = ready;
  assign CKE   = 1'b1;
  assign nDOE  = ~(EN80 & nWE);
  assign nVOE  = PHI1;
  assign RDout = Din;
  assign RDOE  = EN80 & ~nWE80;

endmodule

// File: doc/ram2e_sdram_ctl.md
# ram2e_sdram_ctl

Parametrised SDRAM sequencer for the RAM2E Apple IIe 80-column/RAMWorks card; successor to the fixed CL2, 12-bit-row, implicit-reset controller. Runs on C14M and slots one video read and one CPU read/write into every PHI cycle. Also performs explicit-reset power-up init, periodic refresh and the RAMWorks bank register. Sits between the IIe slot signals (after the EN80 delay line) and a single x16 SDRAM.

## Interface
- CL, 2, SDRAM CAS latency; legal values 2 and 3.
- ROW_W, 12, SDRAM row-address width; legal values 12 and 13.
- INIT_CYC, 4000, C14M cycles of power-up wait before PRECHARGE ALL.
- INIT_REF, 8, auto-refreshes issued during init.
- REF_PHI, 8, PHI cycles per auto-refresh; power of two, 2..64.
- C14M  in  1  14.318 MHz clock; all logic on posedge except data capture.
- nRST  in  1  asynchronous, active-low reset.
- PHI1, nWE, nWE80, nC07X, EN80  in  1 each  slot timing/control; EN80 is already delayed.
- n8MEGEN, nRWKSEN  in  1 each  jumpers.
- Ain  in  8  multiplexed row/column address.
- Din  in  8  6502 data bus.
- Dout  out  8  CPU read data.
- Vout  out  8  video data.
- nDOE, nVOE  out  1 each  ~(EN80 & nWE), PHI1.
- Ready  out  1  init complete.
- CKE, nCS, nRAS, nCAS, nRWE  out  1 each  SDRAM control.
- BA  out  2  bank address.
- RA  out  ROW_W  SDRAM address.
- DQML, DQMH  out  1 each  byte masks.
- RDin  in  8  SDRAM DQ[7:0] and DQ[15:8] share this bus.
- RDout  out  8  write data = Din.
- RDOE  out  1  EN80 & ~nWE80.

## Operation
- Reset (nRST low), all outputs, immediately:
  - CKE=1; nCS=nRAS=nCAS=nRWE=1; DQML=DQMH=1.
  - BA=0, RA=0, Dout=Vout=0, Ready=0.
  - Bank register 0; slot counter S=0; init FSM in WAIT.
- Reset mid-operation aborts any slot; the full init sequence reruns.
- Init FSM: WAIT → PALL → MRS → IREF → RUN.
  - WAIT: INIT_CYC cycles of NOP.
  - PALL: PRECHARGE ALL (RA[10]=1), then 2 NOP cycles.
  - MRS: mode register write, then 2 NOP cycles. Mode value: A9=1 single write, A6:4=CL, sequential, burst length 1, all other bits 0.
  - IREF: INIT_REF AUTO REFRESH commands, 8 cycles apart.
  - RUN: Ready=1; no further exits except reset.
- Slot counter S: 4 bits.
  - PHI1 rising (PHI1 & ~PHI1 of previous cycle) with Ready: S←1, even mid-sequence.
  - Otherwise S holds at 0 or 15, else increments.
- Slots in RUN; any slot not listed drives NOP with DQM=11.
  - S2: ACTIVATE, BA=0, RA[7:0] = row latched at S15, upper RA=0.
  - S3: READ with auto-precharge; RA[7:0]=Ain, DQML=0, DQMH=1. DQM stays 0/1 for CL cycles.
  - S7: latch RA[7:0]=Ain. Latch bank-select qualifier Q = Ain[0] & ~Ain[3] & ~nWE.
  - S8: ACTIVATE; BA=bank[5:4], RA[11:8]=bank[3:0]. When ROW_W=13, RA[12]=bank[7].
  - S9: READ/WRITE with auto-precharge; nRWE=nWE80, RA[7:0]=Ain. DQML=bank[6], DQMH=~bank[6]; masks held for CL cycles.
  - S11: if ~nC07X & Q, bank ← 0 if ~nRWKSEN, else Din[5:0] zero-extended if n8MEGEN, else Din[7:0].
  - S13: AUTO REFRESH when the PHI-cycle counter (incremented at every S←1, wraps mod REF_PHI) is 0.
  - S15: latch RA[7:0]=Ain for the next video row.
- Width rule: bank[7] is ignored when ROW_W=12.

## Timing
- Vout captured on C14M negedge while S = 3+CL+1 (S6 at CL2, S7 at CL3).
- Dout captured on C14M negedge while S = 9+CL+1 (S12 at CL2, S13 at CL3).
- At CL3 the refresh in S13 follows the negedge capture; legal, because the CPU row is already auto-precharged.
- PHI1 edges before Ready are ignored; S stays 0.
- Bank write takes effect from the next S8.

## Configuration
- RWBANK_EN defined: RAMWorks bank register behaves as above.
- RWBANK_EN undefined: register, Q latch and S11 logic removed; bank reads as constant 0, so BA=0, RA[upper]=0, DQML=0, DQMH=1 in CPU slots.

## Structure
- Package ram2e_pkg holds:
  - SDRAM command encoding constants (NOP, ACT, RD, WR, REF, PALL, MRS) as {nCS,nRAS,nCAS,nRWE};
  - the mode-register builder constant;
  - the slot index constants and the init-state typedef.
- Sub-module ram2e_init_seq: WAIT/PALL/MRS/IREF/RUN FSM and its counter, outputting the init command and Ready.

## Test plan
- Release reset: first PALL at cycle INIT_CYC, MRS 3 cycles later with RA[6:4]=CL. Then INIT_REF REFs 8 apart, then Ready=1.
- Ready, PHI1 rise, Ain row 0x12 at S15 and column 0x34 at S3, model returns 0xA5 → ACT row 0x12 bank 0 at S2, READ col 0x34 at S3, Vout=0xA5 after negedge S6 (CL=2).
- CPU write 0x5A at row 0x01, nC07X=0, nWE=0, jumpers enabled, n8MEGEN=0, Din=0xC3 at S11 → bank=0xC3. The next CPU ACT has BA=0, RA[11:8]=3, DQML=1, DQMH=0.
- Same write with nRWKSEN=1 → bank stays 0.
- Count REF commands over 32 PHI cycles with REF_PHI=8 → exactly 4, all at S13.
- Assert nRST during S9 → outputs go to reset values at once. After release, init reruns; no CPU/video command before Ready.
